// File: rtl/fan_off_timer_pkg.sv
// Shared types and constants for the fan auto-off timer and the
// BCD MM:SS countdown reused by the stopwatch/alarm blocks.
package fan_off_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_EXPIRE = 2'd2;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC10_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX = 4'd9;

    // Binary minutes (0..59) to {tens, ones} BCD.
    function automatic logic [7:0] min_to_bcd(input logic [5:0] m);
        logic [5:0] tens;
        tens = m / 6'd10;
        return {4'(tens), 4'(m - tens * 6'd10)};
    endfunction

endpackage

// File: rtl/fan_off_timer_bcd_mmss_down.sv
// Registered BCD MM:SS countdown with clear, load and borrow decrement.
// Priority: clr > load > dec; never decrements below 00:00.
module bcd_mmss_down
    import fan_off_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_min_10,
    input  logic [3:0] load_min_1,
    input  logic       dec,
    output logic [3:0] sec_1,
    output logic [3:0] sec_10,
    output logic [3:0] min_1,
    output logic [3:0] min_10,
    output logic       is_zero
);

    bcd_t sec_1_q, sec_10_q, min_1_q, min_10_q;
    bcd_t sec_1_d, sec_10_d, min_1_d, min_10_d;

    assign is_zero = (sec_1_q == 4'd0) && (sec_10_q == 4'd0) &&
                     (min_1_q == 4'd0) && (min_10_q == 4'd0);

    always_comb begin
        sec_1_d  = sec_1_q;
        sec_10_d = sec_10_q;
        min_1_d  = min_1_q;
        min_10_d = min_10_q;
        if (clr) begin
            sec_1_d  = 4'd0;
            sec_10_d = 4'd0;
            min_1_d  = 4'd0;
            min_10_d = 4'd0;
        end else if (load) begin
            sec_1_d  = 4'd0;
            sec_10_d = 4'd0;
            min_1_d  = load_min_1;
            min_10_d = load_min_10;
        end else if (dec && !is_zero) begin
            if (sec_1_q != 4'd0) begin
                sec_1_d = sec_1_q - 4'd1;
            end else begin
                sec_1_d = DIGIT_MAX;
                if (sec_10_q != 4'd0) begin
                    sec_10_d = sec_10_q - 4'd1;
                end else begin
                    sec_10_d = SEC10_MAX;
                    if (min_1_q != 4'd0) begin
                        min_1_d = min_1_q - 4'd1;
                    end else begin
                        min_1_d  = DIGIT_MAX;
                        min_10_d = min_10_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sec_1_q  <= 4'd0;
            sec_10_q <= 4'd0;
            min_1_q  <= 4'd0;
            min_10_q <= 4'd0;
        end else begin
            sec_1_q  <= sec_1_d;
            sec_10_q <= sec_10_d;
            min_1_q  <= min_1_d;
            min_10_q <= min_10_d;
        end
    end

    assign sec_1  = sec_1_q;
    assign sec_10 = sec_10_q;
    assign min_1  = min_1_q;
    assign min_10 = min_10_q;

endmodule

// File: rtl/fan_off_timer.sv
// Fan auto-off countdown: preset stepping, BCD MM:SS countdown, timeout pulse.
// Define WARN_BLINK_EN to add the warn_blink output for the last 10 seconds.
module fan_off_timer
    import fan_off_timer_pkg::*;
#(
    parameter int STEP_MIN    = 1,
    parameter int NUM_PRESETS = 3
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_timer,
    input  logic       btn_cancel,
    input  logic       fan_on,
    output logic [3:0] sec_1,
    output logic [3:0] sec_10,
    output logic [3:0] min_1,
    output logic [3:0] min_10,
    output logic [1:0] preset_idx,
    output logic       timer_active,
`ifdef WARN_BLINK_EN
    output logic       warn_blink,
`endif
    output logic       timeout_p
);

    if (STEP_MIN < 1 || NUM_PRESETS < 1 || NUM_PRESETS > 3 ||
        NUM_PRESETS * STEP_MIN > 59) begin : g_bad_cfg
        $error("fan_off_timer: NUM_PRESETS*STEP_MIN must be 1..59, NUM_PRESETS 1..3");
    end

    localparam logic [1:0] MAX_PRE = 2'(NUM_PRESETS);

    state_t     state_q, state_d;
    logic [1:0] preset_q, preset_d;
    logic       timeout_q, timeout_d;
    logic       active_q, active_d;

    logic       cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [1:0] nxt_pre;
    logic [7:0] load_bcd;
    logic       at_one;

    // Preset is 0 in IDLE, so +1 covers both the first press and stepping.
    assign nxt_pre  = preset_q + 2'd1;
    assign load_bcd = min_to_bcd(6'(int'(nxt_pre) * STEP_MIN));
    assign at_one   = (min_10 == 4'd0) && (min_1 == 4'd0) &&
                      (sec_10 == 4'd0) && (sec_1 == 4'd1);

    bcd_mmss_down u_cnt (
        .clk         (clk),
        .reset_p     (reset_p),
        .clr         (cnt_clr),
        .load        (cnt_load),
        .load_min_10 (load_bcd[7:4]),
        .load_min_1  (load_bcd[3:0]),
        .dec         (cnt_dec),
        .sec_1       (sec_1),
        .sec_10      (sec_10),
        .min_1       (min_1),
        .min_10      (min_10),
        .is_zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        preset_d  = preset_q;
        timeout_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (!fan_on) begin
            state_d  = ST_IDLE;
            preset_d = 2'd0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_timer) begin
                        state_d  = ST_RUN;
                        preset_d = nxt_pre;
                        cnt_load = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (btn_cancel) begin
                        state_d  = ST_IDLE;
                        preset_d = 2'd0;
                        cnt_clr  = 1'b1;
                    end else if (btn_timer) begin
                        if (preset_q < MAX_PRE) begin
                            preset_d = nxt_pre;
                            cnt_load = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            preset_d = 2'd0;
                            cnt_clr  = 1'b1;
                        end
                    end else if (tick_sec && !cnt_zero) begin
                        cnt_dec = 1'b1;
                        if (at_one) begin
                            state_d   = ST_EXPIRE;
                            preset_d  = 2'd0;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_EXPIRE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
        active_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            preset_q  <= 2'd0;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            timeout_q <= timeout_d;
            active_q  <= active_d;
        end
    end

    assign preset_idx   = preset_q;
    assign timer_active = active_q;
    assign timeout_p    = timeout_q;

`ifdef WARN_BLINK_EN
    logic warn_q, warn_d;
    logic low_window;

    // Current value <= 00:11, so the tick being applied lands at <= 00:10.
    assign low_window = (min_10 == 4'd0) && (min_1 == 4'd0) &&
                        ((sec_10 == 4'd0) ||
                         ((sec_10 == 4'd1) && (sec_1 <= 4'd1)));

    always_comb begin
        warn_d = warn_q ^ (cnt_dec && low_window);
        if (state_d != ST_RUN || cnt_load) begin
            warn_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn_blink = warn_q;
`endif

endmodule

// File: doc/fan_off_timer.md
Name: fan_off_timer

Overview:
- Auto-off countdown timer for the fan controller, downstream of the tick generator / divider chain.
- Consumes the one-cycle 1 s tick pulse and user button pulses, and keeps a BCD MM:SS remaining time.
- Selects among fixed duration presets.
- Emits a one-cycle timeout pulse that the fan mode logic uses to switch the fan off.

Parameters:
- STEP_MIN, 1: minutes added per preset step; preset k loads k*STEP_MIN minutes.
- NUM_PRESETS, 3: number of non-zero presets. Constraint: NUM_PRESETS*STEP_MIN <= 59, checked at elaboration.

Ports:
- clk  in  1  system clock
- reset_p  in  1  reset, synchronous, active-high
- tick_sec  in  1  one-cycle pulse, once per second
- btn_timer  in  1  one-cycle pulse (already debounced/edge-detected); steps the preset
- btn_cancel  in  1  one-cycle pulse; aborts the countdown
- fan_on  in  1  level; fan currently running
- sec_1, sec_10, min_1, min_10  out  4 each  BCD remaining time
- preset_idx  out  2  current preset, 0 = timer off
- timer_active  out  1  high in RUN
- timeout_p  out  1  one-cycle pulse on expiry

Behaviour:
- Reset is synchronous: on a clk edge with reset_p=1, all outputs go to 0 and the state goes to IDLE. This applies mid-countdown too.
- States: IDLE, RUN, EXPIRE. All outputs are registered.
- Priority each cycle: reset_p > fan_on==0 > btn_cancel > btn_timer > tick_sec.
- fan_on==0 (any state):
  - go to IDLE, clear the digits and preset_idx.
  - timeout_p stays 0 (no pulse).
- btn_cancel in RUN: go to IDLE, digits=0, preset_idx=0, no timeout_p. Ignored in IDLE.
- btn_timer in IDLE (fan_on=1): preset_idx=1, load min=STEP_MIN (BCD), sec=00, go to RUN.
- btn_timer in RUN:
  - if preset_idx<NUM_PRESETS: preset_idx+1, reload min=preset_idx_new*STEP_MIN, sec=00. The restart is a full reload, not additive.
  - if preset_idx==NUM_PRESETS: go to IDLE, clear everything, no timeout_p.
- tick_sec in RUN, BCD borrow decrement:
  - sec_1>0: sec_1-1.
  - else sec_1=9, then:
    - sec_10>0: sec_10-1.
    - else sec_10=5, then:
      - min_1>0: min_1-1.
      - else min_1=9, min_10-1.
- Expiry: a tick when the value is 00:01 makes the value 00:00 and moves to EXPIRE.
  - EXPIRE lasts exactly one cycle, with timeout_p=1 and preset_idx cleared.
  - The next cycle is IDLE.
  - timeout_p is therefore 1 cycle after the expiring tick.
- Simultaneous btn_timer and tick_sec: the button is applied and that tick is dropped. The reloaded value is not decremented.
- Inputs in EXPIRE are ignored, except reset_p and fan_on==0. fan_on==0 still forces IDLE, but the pulse already in flight completes.
- tick_sec in IDLE is ignored.
- Digits are always valid BCD: sec_10<=5, others <=9.
- timer_active = (state==RUN).

Optional Feature:
- Macro WARN_BLINK_EN.
- When defined:
  - extra output port warn_blink (1 bit, reset 0).
  - In RUN, when remaining time <= 00:10, warn_blink toggles on each tick_sec. It is 0 in all other states and cleared on leaving RUN.
- When undefined: no port and no toggle logic; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE=0, RUN=1, EXPIRE=2);
  - a BCD digit typedef (4 bits);
  - constants SEC10_MAX=5 and DIGIT_MAX=9.
- One sub-module: bcd_mmss_down, the combinational/registered MM:SS borrow decrement with load port and zero flag. It is reused by the stopwatch/alarm blocks.

Test Plan:
- Reset while RUN at 00:45 (reset_p for 1 clk edge) -> next cycle all outputs 0, state IDLE. A reset_p pulse between edges has no effect.
- STEP_MIN=1, btn_timer in IDLE, then 60 ticks -> 00:59, 00:58 … 00:01, 00:00. timeout_p high exactly 1 cycle, 1 clk after tick 60, then preset_idx=0.
- Borrow check: load 10:00 via STEP_MIN=10, one tick -> 09:59. Then tick_sec with btn_timer in the same cycle -> reload 20:00, preset_idx=2, no decrement.
- Preset cycling, NUM_PRESETS=3: btn_timer x4 -> preset_idx 1,2,3,0. Last press gives IDLE, digits 00:00, no timeout_p.
- Cancel and fan_off: RUN at 02:30 + btn_cancel -> IDLE, no pulse. RUN at 00:01, fan_on=0 with a tick in the same cycle -> IDLE, timeout_p never asserted.
- WARN_BLINK_EN defined, countdown from 00:12 -> warn_blink first toggles on the tick that reaches 00:10 and toggles on every tick after. It is 0 after EXPIRE.
